menu_text_layer: RTL and testbench
==================================

Name: menu_text_layer

Overview:
- Text-mode pixel stage between the SoC character-write interface and the HDMI encoder.
- Holds the game-menu character buffer (ROWS x COLS bytes) written by the SoC via single-cycle write strobes.
- Turns the encoder's x/y scan position into a font ROM address, then turns the returned font byte into a 24-bit pixel colour.
- Highlights the selected menu row and clears itself after reset or on command.

Parameters:
- COLS, 16, characters per menu row; buffer column index width is clog2(COLS).
- ROWS, 8, menu rows; row index width is clog2(ROWS).
- START_COL, 32, first character column of the menu window (8-pixel cells).
- START_ROW, 8, first character row of the menu window (16-pixel cells).
- FG_COLOR, 24'hffffff, normal text colour.
- HL_COLOR, 24'hffff00, selected-row text colour.
- CLR_CHAR, 8'h20, fill byte written by a clear sweep.

Ports:
- clk_25mhz  in  1  pixel/system clock.
- resetn  in  1  asynchronous active-low reset.
- x  in  10  encoder pixel column.
- y  in  10  encoder pixel row.
- wr_en  in  1  character write strobe; accepted only when wr_ready=1.
- wr_col  in  clog2(COLS)  write column.
- wr_row  in  clog2(ROWS)  write row.
- wr_ch  in  8  character byte to write.
- wr_ready  out  1  high when writes are accepted; low during a clear sweep.
- clr  in  1  single-cycle pulse that starts a clear sweep.
- sel  in  clog2(ROWS)  highlighted menu row.
- font_addr  out  12  {char[7:0], y[3:0]} to font ROM, which has 1-cycle registered read.
- font_data  in  8  font row byte; MSB is the leftmost pixel.
- color  out  24  pixel colour.

Behaviour:
- Reset (async, resetn=0):
  - All pipeline registers are 0, so color=0 and font_addr=0.
  - FSM enters CLEAR with the sweep counter at 0.
  - wr_ready=0.
  - Buffer RAM contents are not reset; the clear sweep defines them.
- FSM states: CLEAR and IDLE.
  - CLEAR: writes CLR_CHAR to entry cnt each cycle, with cnt running 0..ROWS*COLS-1. After the last entry, go to IDLE, set wr_ready=1, and set cnt=0. A sweep takes exactly ROWS*COLS cycles (128 at default).
  - IDLE: clr=1 goes to CLEAR with cnt=0, and wr_ready falls on the next cycle.
  - clr in CLEAR restarts the sweep at cnt=0.
  - Reset asserted mid-sweep returns to CLEAR, cnt=0.
- Writes:
  - A write is accepted in IDLE when wr_en=1 and wr_ready=1. buf[wr_row*COLS+wr_col] <= wr_ch at that edge.
  - wr_en while wr_ready=0 is dropped silently, with no queuing.
  - If clr and wr_en are both high in IDLE on the same cycle, clr wins and the write is dropped.
  - wr_col >= COLS or wr_row >= ROWS is ignored. Only reachable with non-power-of-2 parameters.
- Pixel pipeline, with x/y sampled in cycle t:
  - Region test: xc=x[9:3], yc=y[9:4]. in_win = START_COL<=xc<START_COL+COLS and START_ROW<=yc<START_ROW+ROWS.
  - Edge end of t: registered buffer read at (yc-START_ROW)*COLS+(xc-START_COL). The following are also registered: in_win, y[3:0], x[2:0], and row_hl = (yc-START_ROW==sel).
  - Cycle t+1: font_addr = in_win_q ? {char_q, y_q[3:0]} : 12'h000. font_addr is combinational from registers.
  - Edge end of t+1: delay x[2:0], in_win and row_hl one more stage to align with font_data.
  - Edge end of t+2: color <= (in_win_q2 && font_data[7-xs_q2]) ? (row_hl_q2 ? HL_COLOR : FG_COLOR) : 24'h000000.
  - Total latency x/y to color is 3 cycles, fixed. The upstream encoder is responsible for compensating.
- Buffer read port during CLEAR: returns stale or newly cleared data. Display glitches during a clear sweep are permitted.
- A write to the entry being read in the same cycle returns the old value (read-before-write).

Optional Feature:
- MENU_BLINK_EN defined:
  - A 5-bit frame counter increments on each cycle where x==0 && y==0. It resets to 0.
  - While counter[4]=1, selected-row text is drawn in background colour (hidden) instead of HL_COLOR.
  - Result: a 16-frames-on / 16-frames-off blink.
- MENU_BLINK_EN undefined:
  - No counter is present.
  - The selected row is always drawn in HL_COLOR.

Test Plan:
- Release resetn; count cycles -> wr_ready stays 0 for exactly 128 cycles then goes 1; sampling any window cell gives font_addr[11:4]=8'h20.
- Write wr_row=2, wr_col=5, wr_ch=8'h41; drive x=(32+5)*8, y=(8+2)*16+3 -> font_addr=12'h413 one cycle later. With font_data=8'h80, color=24'hffffff three cycles after x/y.
- Same cell with sel=2 -> color=24'hffff00. With x=(32+5)*8+1, font_data=8'h80 -> color=0. Pixel outside the window (x=0, y=0) -> font_addr=0, color=0.
- Pulse clr in IDLE with wr_en asserted on the same cycle -> write dropped, wr_ready=0 for 128 cycles, previously written 0x41 reads back 0x20.
- Assert resetn=0 at cnt=60 of a sweep -> color=0 immediately; after release the full 128-cycle sweep repeats.
- MENU_BLINK_EN: generate 16 frame starts with the selected row lit -> the row goes black at the 16th frame and returns after the 32nd.

Source files
------------

// File: rtl/menu_text_layer.sv
// Text-mode menu overlay: character buffer, font ROM addressing and pixel colouring.
// Define MENU_BLINK_EN to make the selected row blink (16 frames on, 16 frames off).
module menu_text_layer #(
    parameter int unsigned COLS      = 16,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned START_COL = 32,
    parameter int unsigned START_ROW = 8,
    parameter logic [23:0] FG_COLOR  = 24'hffffff,
    parameter logic [23:0] HL_COLOR  = 24'hffff00,
    parameter logic [7:0]  CLR_CHAR  = 8'h20
) (
    input  logic                      clk_25mhz,
    input  logic                      resetn,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      wr_en,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [7:0]                wr_ch,
    output logic                      wr_ready,
    input  logic                      clr,
    input  logic [$clog2(ROWS)-1:0]   sel,
    output logic [11:0]               font_addr,
    input  logic [7:0]                font_data,
    output logic [23:0]               color
);

    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned DEPTH  = ROWS * COLS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              wr_ready_next;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [7:0]        mem_wdata_c;
    logic              wr_in_range_c;

    logic [7:0]        mem [DEPTH];

    assign wr_in_range_c = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);

    // Control state register
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            wr_ready <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wr_ready <= wr_ready_next;
        end
    end

    // Clear sweep sequencing and write-port arbitration (clr beats a same-cycle write)
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        wr_ready_next = wr_ready;
        mem_we_c      = 1'b0;
        mem_waddr_c   = cnt;
        mem_wdata_c   = CLR_CHAR;
        case (state)
            ST_CLEAR: begin
                mem_we_c = 1'b1;
                if (clr) begin
                    cnt_next = '0;
                end else if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next    = ST_IDLE;
                    cnt_next      = '0;
                    wr_ready_next = 1'b1;
                end else begin
                    cnt_next = cnt + ADDR_W'(1);
                end
            end
            default: begin
                if (clr) begin
                    state_next    = ST_CLEAR;
                    cnt_next      = '0;
                    wr_ready_next = 1'b0;
                end else if (wr_en && wr_ready && wr_in_range_c) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = ADDR_W'(32'(wr_row) * COLS + 32'(wr_col));
                    mem_wdata_c = wr_ch;
                end
            end
        endcase
    end

    // Character buffer storage; contents are defined by the clear sweep, not by reset
    always_ff @(posedge clk_25mhz) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    logic [6:0]        xc;
    logic [5:0]        yc;
    logic              in_win_c;
    logic [ROW_W-1:0]  row_off_c;
    logic [COL_W-1:0]  col_off_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              row_hl_c;

    assign xc        = x[9:3];
    assign yc        = y[9:4];
    assign in_win_c  = (32'(xc) >= START_COL) && (32'(xc) < START_COL + COLS) &&
                       (32'(yc) >= START_ROW) && (32'(yc) < START_ROW + ROWS);
    assign row_off_c = ROW_W'(32'(yc) - START_ROW);
    assign col_off_c = COL_W'(32'(xc) - START_COL);
    assign rd_addr_c = in_win_c ? ADDR_W'(32'(row_off_c) * COLS + 32'(col_off_c)) : '0;
    assign row_hl_c  = (row_off_c == sel);

    logic [7:0]  char_q;
    logic [3:0]  yl_q;
    logic [2:0]  xs_q, xs_q2;
    logic        in_win_q, in_win_q2;
    logic        row_hl_q, row_hl_q2;
    logic        hide_c;
    logic        pixel_on_c;
    logic [23:0] color_next;

    assign font_addr = in_win_q ? {char_q, yl_q} : 12'h000;

`ifdef MENU_BLINK_EN
    logic [4:0] frame_cnt;

    // Frame counter advances once per frame at the top-left scan position
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            frame_cnt <= '0;
        end else if (x == 10'd0 && y == 10'd0) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign hide_c = frame_cnt[4];
`else
    assign hide_c = 1'b0;
`endif

    assign pixel_on_c = in_win_q2 && font_data[3'd7 - xs_q2];
    assign color_next = !pixel_on_c ? 24'h000000 :
                        !row_hl_q2  ? FG_COLOR :
                        hide_c      ? 24'h000000 : HL_COLOR;

    // Three-stage pixel pipeline; the buffer read is read-before-write against the write port
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            char_q    <= '0;
            yl_q      <= '0;
            xs_q      <= '0;
            in_win_q  <= 1'b0;
            row_hl_q  <= 1'b0;
            xs_q2     <= '0;
            in_win_q2 <= 1'b0;
            row_hl_q2 <= 1'b0;
            color     <= '0;
        end else begin
            char_q    <= mem[rd_addr_c];
            yl_q      <= y[3:0];
            xs_q      <= x[2:0];
            in_win_q  <= in_win_c;
            row_hl_q  <= row_hl_c;
            xs_q2     <= xs_q;
            in_win_q2 <= in_win_q;
            row_hl_q2 <= row_hl_q;
            color     <= color_next;
        end
    end

endmodule

// File: tb/tb_menu_text_layer.sv
// Self-checking bench for menu_text_layer: vector table, randomized scan/write traffic
// against a cell-level reference model, and clear/reset/blink sequences.
module tb_menu_text_layer;

    localparam logic [23:0] FG = 24'hffffff;
    localparam logic [23:0] HL = 24'hffff00;
    localparam int N_RAND = 400;

    logic        clk_25mhz = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  x = 10'd1;
    logic [9:0]  y = 10'd0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_col = '0;
    logic [2:0]  wr_row = '0;
    logic [7:0]  wr_ch = '0;
    logic        wr_ready;
    logic        clr = 1'b0;
    logic [2:0]  sel = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [23:0] color;

    logic [7:0]  font_rom [4096];
    logic [7:0]  mdl [128];
    int          checks = 0;
    int          errors = 0;
    int          tb_fc = 0;

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [2:0]  ps;
        logic [11:0] ea;
        logic [23:0] ec;
    } vec_t;

    menu_text_layer dut (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn),
        .x         (x),
        .y         (y),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_ch     (wr_ch),
        .wr_ready  (wr_ready),
        .clr       (clr),
        .sel       (sel),
        .font_addr (font_addr),
        .font_data (font_data),
        .color     (color)
    );

    initial forever #20 clk_25mhz = ~clk_25mhz;

    // Font ROM with one-cycle registered read
    always @(posedge clk_25mhz) font_data <= font_rom[font_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
    endtask

    // Cell-level reference: which character cell is under (px,py) and what colour it should show
    function automatic void model_pix(input logic [9:0] px, input logic [9:0] py, input logic [2:0] ps,
                                      output logic [11:0] ea, output logic [23:0] ec);
        int cx, cy;
        logic [7:0] fb;
        logic [23:0] hl;
        cx = int'(px) / 8 - 32;
        cy = int'(py) / 16 - 8;
        ea = 12'h000;
        ec = 24'h000000;
`ifdef MENU_BLINK_EN
        hl = ((tb_fc % 32) >= 16) ? 24'h000000 : HL;
`else
        hl = HL;
`endif
        if (cx >= 0 && cx < 16 && cy >= 0 && cy < 8) begin
            ea = {mdl[cy * 16 + cx], py[3:0]};
            fb = font_rom[ea];
            if (fb[7 - (int'(px) % 8)]) ec = (cy == int'(ps)) ? hl : FG;
        end
    endfunction

    task automatic apply(input string name, input logic [9:0] px, input logic [9:0] py,
                         input logic [2:0] ps, input logic [11:0] ea, input logic [23:0] ec);
        x = px; y = py; sel = ps;
        tick();
        check({name, " font_addr"}, 32'(font_addr), 32'(ea));
        tick();
        tick();
        check({name, " color"}, 32'(color), 32'(ec));
        if (px == 10'd0 && py == 10'd0) tb_fc += 3;
    endtask

    task automatic wait_ready(input string name, input int exp_n);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    task automatic do_write(input logic [2:0] r, input logic [3:0] c, input logic [7:0] ch);
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_ch = ch;
        tick();
        wr_en = 1'b0;
        mdl[{r, c}] = ch;
    endtask

    initial begin
        vec_t tbl [9];
        logic [11:0] ra [N_RAND];
        logic [23:0] rc [N_RAND];
        logic [11:0] ea;
        logic [23:0] ec;
        logic [9:0]  px, py;

        for (int i = 0; i < 4096; i++) font_rom[i] = 8'($urandom);
        font_rom[12'h413] = 8'h80;
        font_rom[12'h200] = 8'h01;
        font_rom[12'h20F] = 8'h40;

        // Reset state
        repeat (3) @(negedge clk_25mhz);
        check("reset color", 32'(color), 32'd0);
        check("reset font_addr", 32'(font_addr), 32'd0);
        check("reset wr_ready", 32'(wr_ready), 32'd0);

        resetn = 1'b1;
        wait_ready("sweep after reset", 128);
        for (int i = 0; i < 128; i++) mdl[i] = 8'h20;
        model_pix(10'd296, 10'd163, 3'd0, ea, ec);
        apply("cleared cell", 10'd296, 10'd163, 3'd0, 12'h203, ec);
        apply("cleared corner", 10'd263, 10'd128, 3'd3, 12'h200, FG);

        do_write(3'd2, 4'd5, 8'h41);

        tbl[0] = '{10'd296, 10'd163, 3'd0, 12'h413, FG};
        tbl[1] = '{10'd296, 10'd163, 3'd2, 12'h413, HL};
        tbl[2] = '{10'd297, 10'd163, 3'd2, 12'h413, 24'h000000};
        tbl[3] = '{10'd263, 10'd128, 3'd2, 12'h200, FG};
        tbl[4] = '{10'd377, 10'd255, 3'd7, 12'h20F, HL};
        tbl[5] = '{10'd384, 10'd163, 3'd2, 12'h000, 24'h000000};
        tbl[6] = '{10'd255, 10'd163, 3'd2, 12'h000, 24'h000000};
        tbl[7] = '{10'd296, 10'd127, 3'd2, 12'h000, 24'h000000};
        tbl[8] = '{10'd0,   10'd0,   3'd2, 12'h000, 24'h000000};
        for (int i = 0; i < 9; i++)
            apply($sformatf("vec%0d", i), tbl[i].px, tbl[i].py, tbl[i].ps, tbl[i].ea, tbl[i].ec);

        // Back-to-back random scan positions with interleaved random writes
        for (int k = 0; k < N_RAND + 2; k++) begin
            if (k < N_RAND) begin
                if ($urandom % 4 != 0) begin
                    px = 10'(256 + $urandom % 128);
                    py = 10'(128 + $urandom % 128);
                end else begin
                    px = 10'($urandom % 800);
                    py = 10'($urandom % 525);
                    if (px == 10'd0 && py == 10'd0) px = 10'd1;
                end
                x = px; y = py; sel = 3'($urandom);
                model_pix(px, py, sel, ra[k], rc[k]);
                wr_en = ($urandom % 4 == 0);
                wr_row = 3'($urandom); wr_col = 4'($urandom); wr_ch = 8'($urandom);
                if (wr_en) mdl[{wr_row, wr_col}] = wr_ch;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            if (k < N_RAND) check($sformatf("rand%0d font_addr", k), 32'(font_addr), 32'(ra[k]));
            if (k >= 2) check($sformatf("rand%0d color", k - 2), 32'(color), 32'(rc[k - 2]));
        end
        wr_en = 1'b0;

        // clr beats a same-cycle write; writes during the sweep are dropped
        do_write(3'd2, 4'd5, 8'h41);
        clr = 1'b1; wr_en = 1'b1; wr_row = 3'd2; wr_col = 4'd5; wr_ch = 8'h55;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        check("wr_ready after clr", 32'(wr_ready), 32'd0);
        repeat (10) tick();
        wr_en = 1'b1; wr_row = 3'd0; wr_col = 4'd0; wr_ch = 8'h77;
        tick();
        wr_en = 1'b0;
        wait_ready("sweep after clr", 117);
        for (int i = 0; i < 128; i++) mdl[i] = 8'h20;
        model_pix(10'd296, 10'd163, 3'd2, ea, ec);
        apply("cleared after clr", 10'd296, 10'd163, 3'd2, 12'h203, ec);
        apply("dropped write", 10'd256, 10'd128, 3'd3, 12'h200, 24'h000000);

        // Reset in the middle of a sweep
        x = 10'd263; y = 10'd128; sel = 3'd3;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (60) tick();
        check("lit mid sweep", 32'(color), 32'(FG));
        #5 resetn = 1'b0;
        #1;
        check("mid reset color", 32'(color), 32'd0);
        check("mid reset font_addr", 32'(font_addr), 32'd0);
        check("mid reset wr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk_25mhz);
        resetn = 1'b1;
        tb_fc = 0;
        wait_ready("sweep after mid reset", 128);
        apply("corner after mid reset", 10'd263, 10'd128, 3'd3, 12'h200, FG);

`ifdef MENU_BLINK_EN
        do_write(3'd2, 4'd5, 8'h41);
        apply("blink f0", 10'd296, 10'd163, 3'd2, 12'h413, HL);
        for (int f = 1; f <= 32; f++) begin
            x = 10'd0; y = 10'd0;
            tick();
            tb_fc++;
            apply($sformatf("blink f%0d", f), 10'd296, 10'd163, 3'd2, 12'h413,
                  ((f % 32) >= 16) ? 24'h000000 : HL);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
